// File: rtl/legv8_instr_encoder.sv
// Buffered LEGv8 instruction encoder: packs symbolic requests into 32-bit words, queues them and
// drains them to instruction memory at auto-incrementing addresses. Optional macro: ENCODER_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | FIFO empty, no write strobe
// WRITE | FIFO holds at least one word, mem_we asserted
module legv8_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDRW = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rn,
  input  logic [4:0]               in_rm,
  input  logic [25:0]              in_imm,
  input  logic                     base_load,
  input  logic [ADDRW-1:0]         base_addr,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [ADDRW-1:0]         mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t         state, state_nxt;
  logic [31:0]    fifo [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_nxt;
  logic [31:0]    enc_word;
  logic           range_bad;
  logic           accept, push, pop;

  always_comb begin
    enc_word = '0;
    case (in_op)
      3'd0: enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
      3'd1: enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
      3'd2: enc_word = {11'b10001011000, in_rm, 6'b0, in_rn, in_rd};
      3'd3: enc_word = {11'b11001011000, in_rm, 6'b0, in_rn, in_rd};
      3'd4: enc_word = {11'b10001010000, in_rm, 6'b0, in_rn, in_rd};
      3'd5: enc_word = {11'b10101010000, in_rm, 6'b0, in_rn, in_rd};
      3'd6: enc_word = {8'b10110100, in_imm[18:0], in_rd};
      3'd7: enc_word = {6'b000101, in_imm[25:0]};
      default: enc_word = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  // Immediate must sign-extend cleanly from the field width actually encoded.
  always_comb begin
    range_bad = 1'b0;
    case (in_op)
      3'd0, 3'd1: range_bad = !((&in_imm[25:8]) || !(|in_imm[25:8]));
      3'd6:       range_bad = !((&in_imm[25:18]) || !(|in_imm[25:18]));
      default:    range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (accept && range_bad) err <= 1'b1;
  end
`else
  assign range_bad = 1'b0;
  assign err       = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign push   = accept && !range_bad;
  assign pop    = mem_we && mem_ready;

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
      mem_addr <= '0;
      state    <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt != CW'(DEPTH));
      if (base_load)
        mem_addr <= base_addr & ~ADDRW'(3);
      else if (pop)
        mem_addr <= mem_addr + ADDRW'(4);
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (push) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (pop && !push && count == CW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_wdata = mem_we ? fifo[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Self-checking bench for legv8_instr_encoder: directed test-plan cases plus randomized traffic
// against a queue-based reference model. Honours ENCODER_RANGE_CHECK_EN when defined.
module tb_legv8_instr_encoder;
  localparam int DEPTH = 4;
  localparam int ADDRW = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd, in_rn, in_rm;
  logic [25:0]       in_imm;
  logic              base_load;
  logic [ADDRW-1:0]  base_addr;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDRW-1:0]  mem_addr;
  logic [31:0]       mem_wdata;
  logic [CW-1:0]     count;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0]      q[$];
  logic [ADDRW-1:0] m_addr;
  logic             m_err;

  legv8_instr_encoder #(.DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .base_load(base_load), .base_addr(base_addr), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Encoding from the field layout, using place values rather than bit concatenation.
  function automatic logic [31:0] ref_enc(int op, int rd, int rn, int rm, longint unsigned imm);
    longint unsigned opc11[6] = '{64'h7C2, 64'h7C0, 64'h458, 64'h658, 64'h450, 64'h550};
    longint unsigned r;
    if (op <= 1)
      r = opc11[op] * 2097152 + (imm % 512) * 4096 + rn * 32 + rd;
    else if (op <= 5)
      r = opc11[op] * 2097152 + rm * 65536 + rn * 32 + rd;
    else if (op == 6)
      r = 64'hB4 * 16777216 + (imm % 524288) * 32 + rd;
    else
      r = 64'h05 * 67108864 + (imm % 67108864);
    return r[31:0];
  endfunction

  function automatic bit ref_bad(int op, longint unsigned imm);
`ifdef ENCODER_RANGE_CHECK_EN
    if (op <= 1) return !((imm / 256) == 0 || (imm / 256) == 64'h3FFFF);
    if (op == 6) return !((imm / 262144) == 0 || (imm / 262144) == 64'hFF);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    bit acc, pp, bad;
    logic [31:0] w;
    acc = in_valid && (q.size() < DEPTH);
    pp  = (q.size() > 0) && mem_ready;
    w   = ref_enc(int'(in_op), int'(in_rd), int'(in_rn), int'(in_rm), longint'(in_imm));
    bad = ref_bad(int'(in_op), longint'(in_imm));
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (base_load) m_addr = base_addr & ~64'h3;
    else if (pp) m_addr = m_addr + 64'd4;
    if (acc && !bad) q.push_back(w);
    if (acc && bad) m_err = 1'b1;
    #1;
  endtask

  task automatic set_req(input bit v, input int op, input int rd, input int rn, input int rm, input logic [25:0] imm);
    in_valid = v; in_op = 3'(op); in_rd = 5'(rd); in_rn = 5'(rn); in_rm = 5'(rm); in_imm = imm;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 0; in_op = 0; in_rd = 0; in_rn = 0; in_rm = 0; in_imm = 0;
    base_load = 0; base_addr = 0; mem_ready = 0;
    q.delete(); m_addr = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add_latency();
    base_load = 1; base_addr = 64'h103;
    tick();
    base_load = 0;
    mem_ready = 1;
    set_req(1, 2, 3, 1, 2, 26'h0);
    tick();
    set_req(0, 0, 0, 0, 0, 26'h0);
    n_cmp++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL add_mem_we got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 64'h100) begin n_fail++; $display("FAIL add_mem_addr got %h want 100", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'h8B020023) begin n_fail++; $display("FAIL add_mem_wdata got %h want 8b020023", mem_wdata); end
    tick();
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL add_idle_mem_we got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 64'h104) begin n_fail++; $display("FAIL add_next_addr got %h want 104", mem_addr); end
  endtask

  task automatic test_formats();
    logic [31:0] exp_w[3] = '{32'hF8408025, 32'h14000010, 32'hB4000062};
    base_load = 1; base_addr = 64'h0; mem_ready = 0;
    tick();
    base_load = 0;
    set_req(1, 0, 5, 1, 0, 26'd8);    tick();
    set_req(1, 7, 0, 0, 0, 26'h10);   tick();
    set_req(1, 6, 2, 0, 0, 26'd3);    tick();
    set_req(0, 0, 0, 0, 0, 26'h0);
    n_cmp++; if (count !== CW'(3)) begin n_fail++; $display("FAIL fmt_count got %0d want 3", count); end
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_wdata !== exp_w[i]) begin n_fail++; $display("FAIL fmt_word%0d got %h want %h", i, mem_wdata, exp_w[i]); end
      n_cmp++; if (mem_addr !== 64'(4 * i)) begin n_fail++; $display("FAIL fmt_addr%0d got %h want %h", i, mem_addr, 4 * i); end
      tick();
    end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fmt_drained got %b want 0", mem_we); end
  endtask

  task automatic test_full();
    mem_ready = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      set_req(1, 2 + (i % 4), i, i + 1, i + 2, 26'h0);
      tick();
      if (i == DEPTH - 1) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
      end
    end
    set_req(0, 0, 0, 0, 0, 26'h0);
    n_cmp++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_count got %0d want %0d", count, DEPTH); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_still_blocked got %b want 0", in_ready); end
    mem_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++; if (mem_wdata !== q[0]) begin n_fail++; $display("FAIL full_drain%0d got %h want %h", i, mem_wdata, q[0]); end
      tick();
      if (i == 0) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop got %b want 1", in_ready); end
      end
    end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL full_empty got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [ADDRW-1:0] prev;
    mem_ready = 1;
    set_req(1, 3, 7, 8, 9, 26'h0);
    tick();
    prev = mem_addr;
    for (int i = 0; i < 16; i++) begin
      set_req(1, 2 + (i % 4), i, 31 - i, i + 4, 26'h0);
      tick();
      n_cmp++; if (count !== CW'(1) || mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_count%0d got %0d/%b want 1/1", i, count, mem_we); end
      n_cmp++; if (mem_addr !== prev + 64'd4) begin n_fail++; $display("FAIL b2b_addr%0d got %h want %h", i, mem_addr, prev + 64'd4); end
      n_cmp++; if (mem_wdata !== q[0]) begin n_fail++; $display("FAIL b2b_word%0d got %h want %h", i, mem_wdata, q[0]); end
      prev = mem_addr;
    end
    set_req(0, 0, 0, 0, 0, 26'h0);
    tick();
  endtask

  task automatic test_async_reset();
    mem_ready = 0;
    base_load = 1; base_addr = 64'h40;
    tick();
    base_load = 0;
    for (int i = 0; i < 3; i++) begin set_req(1, 2, i, i, i, 26'h0); tick(); end
    set_req(0, 0, 0, 0, 0, 26'h0);
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL arst_mem_we got %b want 0", mem_we); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL arst_count got %0d want 0", count); end
    n_cmp++; if (mem_addr !== '0) begin n_fail++; $display("FAIL arst_mem_addr got %h want 0", mem_addr); end
    q.delete(); m_addr = '0; m_err = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

`ifdef ENCODER_RANGE_CHECK_EN
  task automatic test_range_check();
    mem_ready = 0;
    set_req(1, 0, 1, 2, 0, 26'h200);
    tick();
    set_req(0, 0, 0, 0, 0, 26'h0);
    n_cmp++; if (count !== '0 || err !== 1'b1) begin n_fail++; $display("FAIL rc_reject got count %0d err %b want 0/1", count, err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rc_sticky got %b want 1", err); end
    set_req(1, 0, 1, 2, 0, 26'h3FFFFFF);
    tick();
    set_req(0, 0, 0, 0, 0, 26'h0);
    n_cmp++; if (count !== CW'(1) || mem_wdata[20:12] !== 9'h1FF) begin n_fail++; $display("FAIL rc_neg1 got count %0d dt %h want 1/1ff", count, mem_wdata[20:12]); end
    mem_ready = 1;
    tick();
  endtask
`endif

  task automatic test_random();
    int s;
    for (int c = 0; c < 400; c++) begin
      s = $urandom_range(0, 511) - 256;
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31),
              ($urandom_range(0, 1) != 0) ? 26'($urandom) : 26'(s));
      mem_ready = $urandom_range(0, 2) != 0;
      base_load = $urandom_range(0, 19) == 0;
      base_addr = {32'($urandom), 32'($urandom)};
      tick();
      n_cmp++;
      if (count !== CW'(q.size()) || mem_we !== (q.size() > 0) || in_ready !== (q.size() < DEPTH) ||
          mem_addr !== m_addr || err !== m_err ||
          mem_wdata !== ((q.size() > 0) ? q[0] : 32'h0)) begin
        n_fail++;
        $display("FAIL rand%0d got cnt %0d we %b rdy %b addr %h data %h err %b want cnt %0d addr %h data %h err %b",
                 c, count, mem_we, in_ready, mem_addr, mem_wdata, err, q.size(), m_addr,
                 (q.size() > 0) ? q[0] : 32'h0, m_err);
      end
    end
    set_req(0, 0, 0, 0, 0, 26'h0);
    base_load = 0;
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_formats();
    test_full();
    test_back_to_back();
    test_async_reset();
`ifdef ENCODER_RANGE_CHECK_EN
    test_range_check();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/legv8_instr_encoder.md
# legv8_instr_encoder

Buffered LEGv8 instruction encoder: accepts symbolic instructions (op select plus register and immediate fields) over a valid/ready handshake and packs them into 32-bit machine words. Words are queued in a small FIFO and drained to the instruction-memory write port at word-aligned, auto-incrementing addresses. It is the program-loading counterpart of the single-cycle control decoder: it produces the opcodes that the decoder consumes, for testbench and boot-time program loading.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDRW, 64: width of the memory address counter.
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  3  0 LDUR, 1 STUR, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6 CBZ, 7 B.
- in_rd  in  5  Rd (R-type), Rt (LDUR/STUR/CBZ).
- in_rn  in  5  Rn.
- in_rm  in  5  Rm (R-type only).
- in_imm  in  26  DT_address (LDUR/STUR), CondBranchAddr (CBZ), BranchAddr (B); two's complement.
- base_load  in  1  load base_addr into the address counter.
- base_addr  in  ADDRW  start address; bits [1:0] forced to 0.
- mem_we  out  1  write strobe (valid).
- mem_ready  in  1  memory accepts the write.
- mem_addr  out  ADDRW  write address.
- mem_wdata  out  32  encoded instruction.
- count  out  log2(DEPTH)+1  FIFO occupancy.
- err  out  1  sticky range-check error (see Configuration).

## Operation
- Opcodes: LDUR 11111000010, STUR 11111000000, ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, CBZ 10110100, B 000101.
- R-type (ADD/SUB/AND/ORR): {opc11, rm, 6'b0, rn, rd}.
- D-type (LDUR/STUR): {opc11, imm[8:0], 2'b00, rn, rd}.
- CB (CBZ): {opc8, imm[18:0], rd}.
- B: {opc6, imm[25:0]}.
- Fields not used by a format are ignored; upper imm bits are truncated.
- Request accepted when in_valid && in_ready; the encoded word is written to the FIFO tail on that edge.
- Write side: mem_we = FIFO non-empty; mem_wdata = head word; mem_addr = address counter.
- When mem_we && mem_ready: pop head, address counter += 4, wrapping modulo 2^ADDRW.
- base_load: the counter takes {base_addr[ADDRW-1:2], 2'b00} on the next edge.
- base_load has priority over the +4 increment in the same cycle.
- The FIFO head is unaffected by base_load.
- Write engine states: IDLE (empty, mem_we=0) → WRITE (non-empty) → IDLE when the last entry pops with no push in the same cycle.

## Timing
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0; FIFO emptied.
- Reset mid-transfer discards all queued words.
- Latency: a request accepted on edge N gives mem_we=1 with that word after edge N (one cycle) if the FIFO was empty.
- Throughput: one instruction per cycle in each direction.
- in_ready = !full, registered, with no combinational path from mem_ready.
- When full, a same-cycle pop frees a slot; in_ready rises after that edge.
- Simultaneous push and pop when non-empty: count unchanged, order preserved.
- mem_wdata and mem_addr are held stable while mem_we && !mem_ready.

## Configuration
- ENCODER_RANGE_CHECK_EN defined:
  - Accepted LDUR/STUR requests must have imm[25:8] all equal (fits signed 9-bit).
  - Accepted CBZ requests must have imm[25:18] all equal (fits signed 19-bit).
  - A violating request is still handshaken but not enqueued, and sets err (sticky until Reset).
- ENCODER_RANGE_CHECK_EN undefined: no checks; immediates are silently truncated; err tied to 0.

## Test plan
- base_load 0x100; push ADD rd=3 rn=1 rm=2, mem_ready=1 → mem_we one cycle later; mem_addr=0x100, mem_wdata=0x8B020023.
- Push LDUR rd=5 rn=1 imm=8, then B imm=0x10, then CBZ rd=2 imm=3 → words 0xF8408025, 0x14000010, 0xB4000062 at 0x0, 0x4, 0x8.
- mem_ready=0, push DEPTH+1 requests → in_ready low after DEPTH accepts, count=DEPTH; raise mem_ready → in order drain, in_ready high one cycle after first pop.
- Continuous push and pop with mem_ready=1 for 16 cycles → count constant at 1, addresses increment by 4, no gaps.
- Assert Reset with 3 entries queued → mem_we=0, count=0, mem_addr=0 immediately, without waiting for a clock edge.
- With ENCODER_RANGE_CHECK_EN: LDUR imm=0x200 → not written, err=1 and stays 1; LDUR imm=0x3FFFFFF (−1) → accepted, DT field 0x1FF.
